// File: rtl/k10_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : k10_wb_arbiter
// Description : Shares one register-file write port among NUM_REQ writeback
//               requesters; round-robin by default, fixed priority (lowest
//               index wins) when K10_WB_FIXED_PRIO_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module k10_wb_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ-1:0][4:0]   i_req_rd,
    input  logic [NUM_REQ-1:0][31:0]  i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_wr_en,
    output logic [4:0]                o_rd_addr,
    output logic [31:0]               o_rd_data,
    output logic [15:0]               o_conflict_cnt
);

    localparam int          c_PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [NUM_REQ-1:0] w_grant;
    logic [c_PTR_W-1:0] w_gnt_idx;
    logic [c_PTR_W-1:0] w_base;
    logic [c_PTR_W-1:0] w_scan;
    logic [c_PTR_W:0]   w_sum;
    logic               w_any;
    logic               w_hs;
    logic               w_write;
    logic               w_contention;
    logic [4:0]         w_rd;
    logic [31:0]        w_data;

    logic               wr_en_q;
    logic [4:0]         rd_addr_q;
    logic [31:0]        rd_data_q;
    logic [15:0]        cnt_q;
`ifndef K10_WB_FIXED_PRIO_EN
    logic [c_PTR_W-1:0] ptr_q;
`endif

    // Scan requesters starting at the base index, wrapping at NUM_REQ-1.
    always_comb begin
        w_grant   = '0;
        w_gnt_idx = '0;
        w_any     = 1'b0;
        w_sum     = '0;
        w_scan    = '0;
`ifdef K10_WB_FIXED_PRIO_EN
        w_base    = '0;
`else
        w_base    = ptr_q;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, w_base} + (c_PTR_W+1)'(i);
            if (w_sum >= (c_PTR_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (c_PTR_W+1)'(NUM_REQ);
            end
            w_scan = w_sum[c_PTR_W-1:0];
            if (!w_any && i_req_valid[w_scan]) begin
                w_any           = 1'b1;
                w_gnt_idx       = w_scan;
                w_grant[w_scan] = 1'b1;
            end
        end
    end

    assign o_req_ready  = i_rst ? '0 : w_grant;
    assign w_hs         = |o_req_ready;
    assign w_rd         = i_req_rd[w_gnt_idx];
    assign w_data       = i_req_data[w_gnt_idx];
    // A grant to rd==0 is consumed without a write; x0 is never written.
    assign w_write      = w_hs && (w_rd != 5'd0);
    assign w_contention = ($countones(i_req_valid) >= 2);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_en_q   <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_data_q <= 32'd0;
            cnt_q     <= 16'd0;
`ifndef K10_WB_FIXED_PRIO_EN
            ptr_q     <= '0;
`endif
        end else begin
            wr_en_q <= w_write;
            if (w_write) begin
                rd_addr_q <= w_rd;
                rd_data_q <= w_data;
            end
            if (w_contention && (cnt_q != c_CNT_MAX)) begin
                cnt_q <= cnt_q + 16'd1;
            end
`ifndef K10_WB_FIXED_PRIO_EN
            if (w_hs) begin
                ptr_q <= (w_gnt_idx == c_PTR_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
            end
`endif
        end
    end

    assign o_wr_en        = wr_en_q;
    assign o_rd_addr      = rd_addr_q;
    assign o_rd_data      = rd_data_q;
    assign o_conflict_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_k10_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_k10_wb_arbiter
// Description : Self-checking bench for k10_wb_arbiter with a queue-based
//               scoreboard and an arbitration reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_k10_wb_arbiter;

    localparam int N = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         valid;
    logic [N-1:0][4:0]    rd;
    logic [N-1:0][31:0]   data;
    logic [N-1:0]         ready;
    logic                 wr_en;
    logic [4:0]           rd_addr;
    logic [31:0]          rd_data;
    logic [15:0]          conflict_cnt;

    always #5 clk = ~clk;

    k10_wb_arbiter #(.NUM_REQ(N)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (valid),
        .i_req_rd       (rd),
        .i_req_data     (data),
        .o_req_ready    (ready),
        .o_wr_en        (wr_en),
        .o_rd_addr      (rd_addr),
        .o_rd_data      (rd_data),
        .o_conflict_cnt (conflict_cnt)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [N-1:0] rdy; int cnt; } cyc_exp_t;
    typedef struct { int when; logic [4:0] a; logic [31:0] d; } wr_exp_t;
    cyc_exp_t cyc_q[$];
    wr_exp_t  wr_q[$];

    // Reference state: rotating start index and contention count (-1 = unknown).
    int m_ptr = 0;
    int m_cnt = -1;

    logic [N-1:0]       s_v  = '0;
    logic [N-1:0][4:0]  s_rd = '0;
    logic [N-1:0][31:0] s_d  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] v);
        int base;
`ifdef K10_WB_FIXED_PRIO_EN
        base = 0;
`else
        base = m_ptr;
`endif
        for (int i = 0; i < N; i++) begin
            if (v[(base + i) % N]) return (base + i) % N;
        end
        return -1;
    endfunction

    task automatic drive(input logic r, input logic [N-1:0] v,
                         input logic [N-1:0][4:0] a, input logic [N-1:0][31:0] d,
                         output int g);
        cyc_exp_t e;
        wr_exp_t  w;
        @(posedge clk);
        #1;
        rst   = r;
        valid = v;
        rd    = a;
        data  = d;
        g     = r ? -1 : model_pick(v);
        e.rdy = '0;
        if (g >= 0) e.rdy[g] = 1'b1;
        e.cnt = m_cnt;
        cyc_q.push_back(e);
        if (g >= 0) begin
            if (a[g] != 5'd0) begin
                w.when = cyc + 1;
                w.a    = a[g];
                w.d    = d[g];
                wr_q.push_back(w);
            end
            m_ptr = (g + 1) % N;
        end
        if (r) begin
            m_cnt = 0;
            m_ptr = 0;
        end else if ($countones(v) >= 2 && m_cnt >= 0 && m_cnt < 65535) begin
            m_cnt++;
        end
    endtask

    // Requesters hold their request until granted, then may issue a new one.
    task automatic step_rand(input int pct);
        int  g;
        logic r;
        for (int i = 0; i < N; i++) begin
            if (!s_v[i] && $urandom_range(1, 100) <= pct) begin
                s_v[i]  = 1'b1;
                s_rd[i] = 5'($urandom_range(0, 31));
                s_d[i]  = $urandom;
            end
        end
        r = (pct < 100) && ($urandom_range(0, 99) == 0);
        drive(r, s_v, s_rd, s_d, g);
        if (g >= 0) s_v[g] = 1'b0;
    endtask

    // Monitor: per-cycle ready/count check and write-port scoreboard.
    always @(negedge clk) begin
        cyc_exp_t e;
        wr_exp_t  w;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            chk("ready", 32'(ready), 32'(e.rdy));
            if (e.cnt >= 0) chk("conflict_cnt", 32'(conflict_cnt), 32'(e.cnt));
        end
        while (wr_q.size() > 0 && wr_q[0].when < cyc) begin
            w = wr_q.pop_front();
            chk("missing_write_addr", 32'(wr_en), 32'd1);
        end
        if (wr_en === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write", 32'(wr_en), 32'd0);
            end else begin
                w = wr_q.pop_front();
                chk("write_cycle", 32'(cyc), 32'(w.when));
                chk("write_addr",  32'(rd_addr), 32'(w.a));
                chk("write_data",  rd_data, w.d);
            end
        end
    end

    initial begin
        int g;
        logic [N-1:0][4:0]  a;
        logic [N-1:0][31:0] d;
        logic [N-1:0]       exp_r;
        rst = 1'b1; valid = '0; rd = '0; data = '0;

        drive(1'b1, '0, '0, '0, g);
        drive(1'b1, '0, '0, '0, g);
        drive(1'b0, '0, '0, '0, g);
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_addr",  32'(rd_addr), 32'd0);
        chk("rst_data",  rd_data, 32'd0);
        chk("rst_cnt",   32'(conflict_cnt), 32'd0);

        // Single request, latency-1 write.
        a = '0; d = '0; a[0] = 5'd5; d[0] = 32'hDEADBEEF;
        drive(1'b0, 3'b001, a, d, g);
        #1 chk("s1_ready", 32'(ready), 32'd1);
        drive(1'b0, '0, '0, '0, g);
        #1;
        chk("s1_wr_en", 32'(wr_en), 32'd1);
        chk("s1_addr",  32'(rd_addr), 32'd5);
        chk("s1_data",  rd_data, 32'hDEADBEEF);

        // All three valid continuously.
        drive(1'b1, '0, '0, '0, g);
        for (int i = 0; i < N; i++) begin
            a[i] = 5'(i + 1);
            d[i] = 32'h100 + 32'(i);
        end
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 3'b111, a, d, g);
`ifdef K10_WB_FIXED_PRIO_EN
            exp_r = 3'b001;
`else
            exp_r = 3'(1 << (k % 3));
`endif
            #1 chk("s2_grant", 32'(ready), 32'(exp_r));
        end
        drive(1'b0, '0, '0, '0, g);
        #1 chk("s2_cnt", 32'(conflict_cnt), 32'd6);

        // rd==0 consumes the grant without a write, pointer moves past it.
        drive(1'b1, '0, '0, '0, g);
        a[1] = 5'd0; d[1] = 32'h1234;
        drive(1'b0, 3'b010, a, d, g);
        #1 chk("s4_ready", 32'(ready), 32'b010);
        a[1] = 5'd9;
        drive(1'b0, 3'b111, a, d, g);
`ifdef K10_WB_FIXED_PRIO_EN
        exp_r = 3'b001;
`else
        exp_r = 3'b100;
`endif
        #1;
        chk("s4_wr_en", 32'(wr_en), 32'd0);
        chk("s4_ptr", 32'(ready), 32'(exp_r));

        // Reset pulse while req2 pending with the pointer at 2.
        drive(1'b1, '0, '0, '0, g);
        drive(1'b0, 3'b010, a, d, g);
        drive(1'b1, 3'b100, a, d, g);
        #1 chk("s6_rst_ready", 32'(ready), 32'd0);
        drive(1'b0, 3'b100, a, d, g);
        #1 chk("s6_req2", 32'(ready), 32'b100);
        drive(1'b0, '0, '0, '0, g);
        #1 chk("s6_req2_write", 32'(rd_addr), 32'(a[2]));
        drive(1'b0, 3'b111, a, d, g);
        #1 chk("s6_ptr0", 32'(ready), 32'b001);

        // Randomized traffic with occasional reset.
        drive(1'b1, '0, '0, '0, g);
        for (int k = 0; k < 400; k++) step_rand(50);

        // Sustained contention saturates the counter.
        s_v = '0;
        drive(1'b1, '0, '0, '0, g);
        for (int k = 0; k < 70000; k++) step_rand(100);
        #1 chk("sat_cnt", 32'(conflict_cnt), 32'hFFFF);

        drive(1'b0, '0, '0, '0, g);
        drive(1'b0, '0, '0, '0, g);
        drive(1'b0, '0, '0, '0, g);
        @(negedge clk);
        #1 chk("drain", 32'(wr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/k10_wb_arbiter.md
K10_WB_ARBITER -- requirements
Module: k10_wb_arbiter

Interface
REQ-001 SHALL have parameter: NUM_REQ, 3, number of writeback requesters (legal 2..8).
REQ-002 SHALL have ports:
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  reset: synchronous, active-high.
- i_req_valid  in  NUM_REQ  per-requester write request.
- i_req_rd  in  NUM_REQ x 5  per-requester destination register.
- i_req_data  in  NUM_REQ x 32  per-requester write data.
- o_req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- o_wr_en  out  1  register-file write enable.
- o_rd_addr  out  5  register-file write address.
- o_rd_data  out  32  register-file write data.
- o_conflict_cnt  out  16  saturating count of contention cycles.

Function
REQ-003 SHALL share the register file's single write port among NUM_REQ requesters.
REQ-004 Handshake SHALL complete when i_req_valid[n] and o_req_ready[n] are both high on a rising edge.
REQ-005 Requesters SHALL hold valid, rd and data stable until accepted; the arbiter does not check this.
REQ-006 o_req_ready SHALL be combinational from i_req_valid and the arbitration state.
REQ-007 Exactly one valid requester SHALL be granted per cycle when any is valid; o_req_ready SHALL be all-zero when none is valid.
REQ-008 The winner's rd/data SHALL be registered; o_wr_en/o_rd_addr/o_rd_data SHALL appear the cycle after the handshake (latency 1).
REQ-009 o_wr_en SHALL be high only in cycles following an accepted handshake; otherwise low.
REQ-010 A handshake with rd==0 SHALL be accepted and consume its grant, with o_wr_en low the next cycle.
REQ-011 o_rd_addr/o_rd_data SHALL hold their last values when o_wr_en is low.
REQ-012 Round-robin pointer ptr (width clog2(NUM_REQ)): search order SHALL be ptr, ptr+1, ... wrapping at NUM_REQ-1 to 0.
REQ-013 After a grant to index g, ptr SHALL become (g+1) mod NUM_REQ; with no grant, ptr SHALL be unchanged.
REQ-014 A continuously valid requester SHALL be granted within NUM_REQ cycles.
REQ-015 Back-to-back grants to the same requester SHALL be allowed when it is the only one valid.
REQ-016 o_conflict_cnt SHALL increment by 1 in each cycle with two or more valid requesters, and saturate at 16'hFFFF.
REQ-017 No backpressure SHALL come from the register file; the output register SHALL accept every cycle.

Reset
REQ-018 While i_rst is high at a rising edge, the following SHALL be cleared to 0: o_wr_en, o_rd_addr, o_rd_data, o_conflict_cnt and ptr.
REQ-019 o_req_ready SHALL be all-zero whenever i_rst is high.
REQ-020 A request pending when reset asserts SHALL be dropped with no write; after reset deasserts it is re-arbitrated from ptr=0.

Configuration
REQ-021 Macro K10_WB_FIXED_PRIO_EN SHALL select the arbitration policy.
REQ-022 With K10_WB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; ptr is removed and REQ-012..014 do not apply.
REQ-023 With K10_WB_FIXED_PRIO_EN undefined: round-robin per REQ-012..014.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then req0 valid rd=5 data=0xDEADBEEF -> ready[0] in cycle 0; cycle 1: o_wr_en=1, o_rd_addr=5, o_rd_data=0xDEADBEEF.
- All three valid continuously (round-robin) -> grant order 0,1,2,0,1,2; o_conflict_cnt increases by 1 per cycle.
- Same stimulus with K10_WB_FIXED_PRIO_EN -> req0 granted every cycle; req1 and req2 are never granted while req0 is valid.
- req1 valid rd=0 data=0x1234 -> ready[1]=1; next cycle o_wr_en=0; ptr advances to 2.
- Contention sustained for 70000 cycles -> o_conflict_cnt stops at 0xFFFF.
- i_rst pulsed while req2 valid with ptr=2 -> ready all-zero during reset, no write; after reset req2 is granted and ptr=0.
